// File: rtl/instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch : PC owner and single-outstanding instruction fetcher that
//               presents the fetched word to decode over a valid/ready handshake
// Revision    : 1.0
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [XLEN-1:0]      imem_rdata,
  output logic [XLEN-1:0]      instr,
  output logic [5:0]           instruc,
  output logic [XLEN-1:0]      instr_pc,
  output logic [XLEN-1:0]      pc_plus4,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc
);

  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_REQ   = 2'd1;
  localparam logic [1:0]      c_WAIT  = 2'd2;
  localparam logic [1:0]      c_HOLD  = 2'd3;
  localparam logic [XLEN-1:0] c_ALIGN = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] c_FOUR  = {{(XLEN-3){1'b0}}, 3'd4};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] w_redir_tgt;
  logic [XLEN-1:0] w_seq_pc;

  assign w_redir_tgt = redirect_pc & c_ALIGN;
  assign w_seq_pc    = instr_pc_q + c_FOUR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= c_IDLE;
      pc_q       <= RESET_PC & c_ALIGN;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC & c_ALIGN;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      c_IDLE: begin
        state_d = c_REQ;
        if (redirect) pc_d = w_redir_tgt;
      end
      c_REQ: begin
        if (imem_gnt) state_d = c_WAIT;
        if (redirect) begin
          pc_d = w_redir_tgt;
          if (imem_gnt) kill_d = 1'b1;
        end
      end
      c_WAIT: begin
        if (redirect) begin
          pc_d   = w_redir_tgt;
          kill_d = 1'b1;
        end
        // Returned data either lands in the IR or, if stale, is dropped and
        // the fetch restarts from the (possibly redirected) pc with kill clear.
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = c_REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = c_HOLD;
          end
        end
      end
      default: begin
        if (instr_ready) begin
          pc_d    = redirect ? w_redir_tgt : w_seq_pc;
          state_d = c_REQ;
        end else if (redirect) begin
          pc_d    = w_redir_tgt;
          state_d = c_REQ;
        end
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == c_REQ);
    instr_valid = (state_q == c_HOLD);
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign instruc   = instr_q[XLEN-1 -: 6];
  assign instr_pc  = instr_pc_q;
  assign pc_plus4  = w_seq_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed, table-driven and randomized checks of instr_fetch
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  instruc;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0400)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instruc     (instruc),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [5:0]  exp_op;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Starts in REQ; ends with the returned word presented in HOLD.
  task automatic fetch(input int gnt_wait, input int rv_wait, input logic [31:0] data);
    imem_gnt = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < rv_wait; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_instr", instr, data);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] resp_addr;
    logic [31:0] want;
    bit          pend;
    int          cnt;
    int          idle;

    vecs[0] = '{32'h0000_1000, 0, 0, 32'hFC00_0000, 32'h0000_1000, 6'h3F, 32'h0000_1004};
    vecs[1] = '{32'h0000_2002, 2, 1, 32'h0000_0001, 32'h0000_2000, 6'h00, 32'h0000_2004};
    vecs[2] = '{32'hFFFF_FFFC, 1, 0, 32'h8C00_1234, 32'hFFFF_FFFC, 6'h23, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 0, 2, 32'h2000_0000, 32'h7FFF_FFFC, 6'h08, 32'h8000_0000};
    vecs[4] = '{32'h0000_0000, 0, 0, 32'h0800_0000, 32'h0000_0000, 6'h02, 32'h0000_0004};

    reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'h400);
    chk("rst_addr", imem_addr, 32'h400);

    // First fetch out of reset
    reset_n  = 1'b1;
    imem_gnt = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h400);
    tick();
    imem_gnt = 1'b0;
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C00_0000;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instruc", {26'd0, instruc}, 32'h23);
    chk("hold_instr_pc", instr_pc, 32'h400);
    chk("hold_pc_plus4", pc_plus4, 32'h404);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h8C00_0000);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("after_ho_valid", {31'd0, instr_valid}, 32'd0);
    chk("after_ho_req", {31'd0, imem_req}, 32'd1);
    chk("after_ho_addr", imem_addr, 32'h404);

    // Misaligned redirect while waiting kills the in-flight word
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    imem_rvalid = 1'b0;
    chk("kill_valid", {31'd0, instr_valid}, 32'd0);
    chk("kill_req", {31'd0, imem_req}, 32'd1);
    chk("kill_addr", imem_addr, 32'h1000);
    fetch(0, 0, 32'h2000_0000);
    chk("kill_instruc", {26'd0, instruc}, 32'h08);
    chk("kill_instr_pc", instr_pc, 32'h1000);

    // Redirect coinciding with handoff
    redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("rho_valid", {31'd0, instr_valid}, 32'd0);
    chk("rho_addr", imem_addr, 32'h200);
    tick();
    chk("rho_once", {31'd0, instr_valid}, 32'd0);

    // Redirect while the request is not granted
    for (int i = 0; i < 2; i++) begin
      chk("nogrant_addr", imem_addr, 32'h200);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("nogrant_req", {31'd0, imem_req}, 32'd1);
    chk("nogrant_addr_new", imem_addr, 32'h80);
    fetch(0, 0, 32'hAC00_0000);
    chk("nogrant_instr_pc", instr_pc, 32'h80);

    // Reset asserted mid-WAIT, stale rvalid after release
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_instr_pc", instr_pc, 32'h400);
    tick();
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_addr", imem_addr, 32'h400);
    fetch(0, 0, 32'h3C00_0000);
    chk("restart_instr_pc", instr_pc, 32'h400);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Table: redirect in ungranted REQ, fetch, then sequential handoff
    for (int v = 0; v < 5; v++) begin
      redirect = 1'b1; redirect_pc = vecs[v].target;
      tick();
      redirect = 1'b0;
      chk("tbl_addr", imem_addr, vecs[v].exp_pc);
      fetch(vecs[v].gnt_wait, vecs[v].rv_wait, vecs[v].rdata);
      chk("tbl_instr_pc", instr_pc, vecs[v].exp_pc);
      chk("tbl_instruc", {26'd0, instruc}, {26'd0, vecs[v].exp_op});
      chk("tbl_pc_plus4", pc_plus4, vecs[v].exp_pc4);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("tbl_next_addr", imem_addr, vecs[v].exp_pc4);
    end

    // Random traffic against a transaction-level model: the next presented
    // instruction comes from the latest redirect target, else previous + 4.
    exp_pc = 32'h4; pend = 0; cnt = 0; idle = 0; resp_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      imem_gnt    = ($urandom_range(3) != 0);
      instr_ready = ($urandom_range(2) != 0);
      redirect    = ($urandom_range(11) == 0);
      redirect_pc = $urandom;
      if (pend && cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = memf(resp_addr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      if (instr_valid && instr_ready) begin
        want = memf(exp_pc);
        chk("rnd_instr_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, want);
        chk("rnd_instruc", {26'd0, instruc}, {26'd0, want[31:26]});
        chk("rnd_pc_plus4", pc_plus4, exp_pc + 32'd4);
        exp_pc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        idle = 0;
      end else begin
        if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        idle++;
      end
      if (imem_rvalid) pend = 0;
      else if (pend) cnt--;
      if (imem_req && imem_gnt) begin
        chk("rnd_one_outstanding", {31'd0, pend}, 32'd0);
        chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        pend = 1; resp_addr = imem_addr; cnt = $urandom_range(2);
      end
      tick();
      if (idle > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_watchdog: got %0d idle cycles expected at most 200", idle);
        break;
      end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redirect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
